nphy_toggle_input_beat_packer: RTL

Parametrised successor to the Toggle-mode DDR input path. It runs entirely in the iSystemClock domain, downstream of the DQS-domain capture/CDC stage, and consumes one rise/fall DDR beat pair per valid cycle. It discards a programmable number of leading beats for alignment, packs the rest into BEATS_PER_WORD-byte words, stops exactly at a programmed byte count with a masked final word, and buffers words in an internal FIFO with a valid/ready output. It replaces fixed Nm1..Nm4 window selection with a generic beat aligner and adds overflow detection.

---
 rtl/nphy_toggle_input_beat_packer_if.sv | 22 ++
 rtl/nphy_toggle_input_beat_packer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/nphy_toggle_input_beat_packer_if.sv
// Output word stream of the Toggle-mode input beat packer.
// master = packer (drives the word), slave = consumer (drives ready).
interface nphy_toggle_input_beat_packer_if #(
    parameter int DQ_WIDTH       = 8,
    parameter int BEATS_PER_WORD = 4
);
    logic                               oWordValid;
    logic                               iWordReady;
    logic [BEATS_PER_WORD*DQ_WIDTH-1:0] oWordData;
    logic [BEATS_PER_WORD-1:0]          oWordMask;
    logic                               oWordLast;

    modport master (
        output oWordValid, oWordData, oWordMask, oWordLast,
        input  iWordReady
    );

    modport slave (
        input  oWordValid, oWordData, oWordMask, oWordLast,
        output iWordReady
    );
endinterface

// File: rtl/nphy_toggle_input_beat_packer.sv
// Toggle-mode DDR input path: skips leading beats, packs rise/fall beat pairs into
// masked words and queues them in an output FIFO with overflow detection.
module nphy_toggle_input_beat_packer #(
    parameter int DQ_WIDTH       = 8,
    parameter int BEATS_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                            iSystemClock,
    input  logic                            iModuleResetN,
    input  logic                            iStart,
    input  logic [CNT_WIDTH-1:0]            iSkipBeats,
    input  logic [CNT_WIDTH-1:0]            iByteCount,
    input  logic                            iBeatValid,
    input  logic [DQ_WIDTH-1:0]             iBeatRise,
    input  logic [DQ_WIDTH-1:0]             iBeatFall,
    nphy_toggle_input_beat_packer_if.master wordIf,
    output logic                            oBusy,
    output logic                            oDone,
    output logic                            oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]     oFifoLevel
);
    localparam int WORD_W = BEATS_PER_WORD * DQ_WIDTH;
    localparam int FILL_W = $clog2(BEATS_PER_WORD + 1);
    localparam int IDX_W  = $clog2(BEATS_PER_WORD);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(BEATS_PER_WORD);
    localparam logic [AW:0]       LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SKIP, PACK, FLUSH, DONE} packState_t;

    packState_t                             rState, nState, wStateD;
    logic [CNT_WIDTH-1:0]                   rSkipCnt, nSkip, wSkipD;
    logic [CNT_WIDTH-1:0]                   rKeepCnt, nKeep, wKeepD;
    logic [FILL_W-1:0]                      rFill, nFill, wFillD;
    logic [BEATS_PER_WORD-1:0][DQ_WIDTH-1:0] rPartial, nPartial, wPartialD;
    logic                                   rBusy, rDone, rOverflow;

    logic                                   wPush, wPushEff, wPushLast, wPop, wFull, wWrite;
    logic [WORD_W-1:0]                      wPushData;
    logic [BEATS_PER_WORD-1:0]              wPushMask;
    logic [BEATS_PER_WORD:0]                wMaskWide;
    logic [DQ_WIDTH-1:0]                    wBeat;

    logic [WORD_W-1:0]                      rFifoData [FIFO_DEPTH];
    logic [BEATS_PER_WORD-1:0]              rFifoMask [FIFO_DEPTH];
    logic                                   rFifoLast [FIFO_DEPTH];
    logic [AW-1:0]                          rWrPtr, rRdPtr;
    logic [AW:0]                            rLevel;

    // Beats of a pair are walked in time order so a skip or keep boundary can fall mid-pair.
    always_comb begin
        nState    = rState;
        nSkip     = rSkipCnt;
        nKeep     = rKeepCnt;
        nFill     = rFill;
        nPartial  = rPartial;
        wPush     = 1'b0;
        wPushData = '0;
        wPushMask = '1;
        wPushLast = 1'b0;
        wBeat     = '0;
        wMaskWide = ({{BEATS_PER_WORD{1'b0}}, 1'b1} << rFill) - 1'b1;

        if (rState == FLUSH) begin
            wPush     = 1'b1;
            wPushData = rPartial;
            wPushMask = wMaskWide[BEATS_PER_WORD-1:0];
            wPushLast = 1'b1;
            nPartial  = '0;
            nFill     = '0;
            nState    = DONE;
        end else if (iBeatValid && (rState == SKIP || rState == PACK)) begin
            for (int unsigned b = 0; b < 2; b++) begin
                wBeat = (b == 0) ? iBeatRise : iBeatFall;
                if (nState == SKIP) begin
                    if (nSkip != '0) nSkip = nSkip - 1'b1;
                    if (nSkip == '0) nState = (nKeep != '0) ? PACK : DONE;
                end else if (nState == PACK && nKeep != '0) begin
                    nPartial[nFill[IDX_W-1:0]] = wBeat;
                    nFill = nFill + 1'b1;
                    nKeep = nKeep - 1'b1;
                    if (nFill == FILL_FULL) begin
                        wPush     = 1'b1;
                        wPushData = nPartial;
                        nPartial  = '0;
                        nFill     = '0;
                    end
                    if (nKeep == '0) begin
                        if (nFill == '0) begin
                            wPushLast = 1'b1;
                            nState    = DONE;
                        end else begin
                            nState = FLUSH;
                        end
                    end
                end
            end
        end

        wStateD   = nState;
        wSkipD    = nSkip;
        wKeepD    = nKeep;
        wFillD    = nFill;
        wPartialD = nPartial;
        if (iStart) begin
            wSkipD    = iSkipBeats;
            wKeepD    = iByteCount;
            wFillD    = '0;
            wPartialD = '0;
            wStateD   = (iSkipBeats != '0) ? SKIP : ((iByteCount != '0) ? PACK : DONE);
        end
    end

    assign wPushEff = wPush && !iStart;
    assign wPop     = (rLevel != '0) && wordIf.iWordReady;
    assign wFull    = (rLevel == LEVEL_FULL);
    assign wWrite   = wPushEff && (!wFull || wPop);

    always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
        if (!iModuleResetN) begin
            rState    <= IDLE;
            rSkipCnt  <= '0;
            rKeepCnt  <= '0;
            rFill     <= '0;
            rPartial  <= '0;
            rBusy     <= 1'b0;
            rDone     <= 1'b0;
            rOverflow <= 1'b0;
            rWrPtr    <= '0;
            rRdPtr    <= '0;
            rLevel    <= '0;
        end else begin
            rState   <= wStateD;
            rSkipCnt <= wSkipD;
            rKeepCnt <= wKeepD;
            rFill    <= wFillD;
            rPartial <= wPartialD;
            rBusy    <= (wStateD == SKIP) || (wStateD == PACK) || (wStateD == FLUSH);
            rDone    <= (wStateD == DONE);
            if (iStart)
                rOverflow <= 1'b0;
            else if (wPushEff && wFull && !wPop)
                rOverflow <= 1'b1;
            if (wWrite) rWrPtr <= rWrPtr + 1'b1;
            if (wPop)   rRdPtr <= rRdPtr + 1'b1;
            case ({wWrite, wPop})
                2'b10:   rLevel <= rLevel + 1'b1;
                2'b01:   rLevel <= rLevel - 1'b1;
                default: rLevel <= rLevel;
            endcase
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (wWrite) begin
            rFifoData[rWrPtr] <= wPushData;
            rFifoMask[rWrPtr] <= wPushMask;
            rFifoLast[rWrPtr] <= wPushLast;
        end
    end

    // Head fields are gated so an empty FIFO presents zeros rather than stale storage.
    assign wordIf.oWordValid = (rLevel != '0);
    assign wordIf.oWordData  = (rLevel != '0) ? rFifoData[rRdPtr] : '0;
    assign wordIf.oWordMask  = (rLevel != '0) ? rFifoMask[rRdPtr] : '0;
    assign wordIf.oWordLast  = (rLevel != '0) && rFifoLast[rRdPtr];

    assign oBusy      = rBusy;
    assign oDone      = rDone;
    assign oOverflow  = rOverflow;
    assign oFifoLevel = rLevel;
endmodule
